// File: rtl/ncejdtm200_pkg.sv
// Shared encodings for the DMI requester arbiter: DMI op codes, FSM states
// and the bit layout of a requester's {addr, wdata, op} bundle.
package ncejdtm200_pkg;

    localparam logic [1:0] DMI_OP_NOP   = 2'b00;
    localparam logic [1:0] DMI_OP_READ  = 2'b01;
    localparam logic [1:0] DMI_OP_WRITE = 2'b10;
    localparam logic [1:0] DMI_OP_RSV   = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_TOUT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam int REQ_OP_LSB     = 0;
    localparam int REQ_WDATA_LSB  = 2;
    localparam int REQ_ADDR_LSB   = 34;
    localparam int REQ_FIXED_BITS = 34;

    // NOP and the reserved op complete locally without touching the DM.
    function automatic logic op_needs_dm(input logic [1:0] op);
        logic needs_dm;
        case (op)
            DMI_OP_NOP:   needs_dm = 1'b0;
            DMI_OP_READ:  needs_dm = 1'b1;
            DMI_OP_WRITE: needs_dm = 1'b1;
            DMI_OP_RSV:   needs_dm = 1'b0;
            default:      needs_dm = 1'b0;
        endcase
        return needs_dm;
    endfunction

endpackage

// File: rtl/ncejdtm200_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, cyclically, returned as a one-hot grant plus its index.
module ncejdtm200_rr_pick
    import ncejdtm200_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int best_pos_s;
    int best_idx_s;
    int pos_s;

    // Rank each requester by its cyclic distance past the pointer and keep the nearest.
    always_comb begin
        best_pos_s = NUM_REQ;
        best_idx_s = 0;
        pos_s      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_s = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
            if (req[i] && (pos_s < best_pos_s)) begin
                best_pos_s = pos_s;
                best_idx_s = i;
            end else begin
                best_pos_s = best_pos_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (best_pos_s < NUM_REQ) && (best_idx_s == i);
        end
        grant_idx = IDX_W'(best_idx_s);
    end

endmodule

// File: rtl/ncejdtm200_dmi_arb.sv
// Round-robin arbiter sharing one DMI target between up to four transports,
// with DM hang timeout and draining of responses orphaned by a requester reset.
module ncejdtm200_dmi_arb
    import ncejdtm200_pkg::*;
#(
    parameter int DMI_ADDR_BITS  = 7,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                        clk,
    input  logic                                        pwr_rst_n,
    input  logic [NUM_REQ-1:0]                          req_vld,
    input  logic [NUM_REQ*(REQ_FIXED_BITS+DMI_ADDR_BITS)-1:0] req_data,
    input  logic [NUM_REQ-1:0]                          req_resetn,
    output logic [NUM_REQ-1:0]                          req_ack,
    output logic [31:0]                                 req_rdata,
    output logic                                        req_err,
    output logic                                        dmi_req,
    output logic [DMI_ADDR_BITS-1:0]                    dmi_addr,
    output logic [31:0]                                 dmi_wdata,
    output logic                                        dmi_wr,
    input  logic                                        dm_ack,
    input  logic [31:0]                                 dm_rdata
);

    localparam int REQ_W = REQ_FIXED_BITS + DMI_ADDR_BITS;
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [NUM_REQ-1:0] eff_req_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [REQ_W-1:0]   req_slot_s [NUM_REQ];
    logic [REQ_W-1:0]   sel_data_s;
    logic [1:0]         sel_op_s;
    logic               owner_live_s;
    logic               tout_hit_s;
    logic               take_s;

    logic [2:0]         state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] owner_oh_r;
    logic [NUM_REQ-1:0] ack_nxt_s;
    logic [31:0]        rdata_nxt_s;
    logic               err_nxt_s;
    logic               dmi_req_nxt_s;

    assign eff_req_s = req_vld & req_resetn;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign req_slot_s[g] = req_data[g*REQ_W +: REQ_W];
    end

    ncejdtm200_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (eff_req_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign sel_data_s   = req_slot_s[grant_idx_s];
    assign sel_op_s     = sel_data_s[REQ_OP_LSB +: 2];
    assign owner_live_s = |(eff_req_s & owner_oh_r);
    assign tout_hit_s   = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_W'(TIMEOUT_CYCLES));

    // Next-state and next-output decode; dm_ack outranks owner drop, which outranks timeout.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        ack_nxt_s     = '0;
        rdata_nxt_s   = 32'h0000_0000;
        err_nxt_s     = 1'b0;
        dmi_req_nxt_s = dmi_req;
        take_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|eff_req_s) begin
                    take_s = 1'b1;
                    if (op_needs_dm(sel_op_s)) begin
                        state_nxt_s   = ST_ISSUE;
                        dmi_req_nxt_s = 1'b1;
                        cnt_nxt_s     = '0;
                    end else begin
                        state_nxt_s = ST_RESP;
                        ack_nxt_s   = grant_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (dm_ack) begin
                    dmi_req_nxt_s = 1'b0;
                    if (owner_live_s) begin
                        state_nxt_s = ST_RESP;
                        ack_nxt_s   = owner_oh_r;
                        rdata_nxt_s = dmi_wr ? 32'h0000_0000 : dm_rdata;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (!owner_live_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (tout_hit_s) begin
                    state_nxt_s = ST_TOUT;
                    ack_nxt_s   = owner_oh_r;
                    err_nxt_s   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            ST_TOUT, ST_DRAIN: begin
                // The DM transaction is still outstanding; only its ack may lower dmi_req.
                if (dm_ack) begin
                    state_nxt_s   = ST_IDLE;
                    dmi_req_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                dmi_req_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM, timeout counter, round-robin pointer and owner tracking.
    always_ff @(posedge clk or negedge pwr_rst_n) begin
        if (!pwr_rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            ptr_r      <= IDX_W'(NUM_REQ - 1);
            owner_oh_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (take_s) begin
                ptr_r      <= grant_idx_s;
                owner_oh_r <= grant_s;
            end else begin
                ptr_r      <= ptr_r;
                owner_oh_r <= owner_oh_r;
            end
        end
    end

    // Registered requester-side and DM-side outputs.
    always_ff @(posedge clk or negedge pwr_rst_n) begin
        if (!pwr_rst_n) begin
            req_ack   <= '0;
            req_rdata <= 32'h0000_0000;
            req_err   <= 1'b0;
            dmi_req   <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= 32'h0000_0000;
            dmi_wr    <= 1'b0;
        end else begin
            req_ack   <= ack_nxt_s;
            req_rdata <= rdata_nxt_s;
            req_err   <= err_nxt_s;
            dmi_req   <= dmi_req_nxt_s;
            if (take_s) begin
                dmi_addr  <= sel_data_s[REQ_ADDR_LSB +: DMI_ADDR_BITS];
                dmi_wdata <= sel_data_s[REQ_WDATA_LSB +: 32];
                dmi_wr    <= (sel_op_s == DMI_OP_WRITE);
            end else begin
                dmi_addr  <= dmi_addr;
                dmi_wdata <= dmi_wdata;
                dmi_wr    <= dmi_wr;
            end
        end
    end

endmodule
